ram: RTL and testbench

RAM -- requirements
Module: ram

---
 rtl/ram.sv | 67 ++++++
 tb/tb_ram.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ram.sv
// Byte-addressed little-endian RAM with byte/halfword/word access,
// misaligned wrap-around, combinational read and async clear.
module ram #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [1:0]  mem_ctrl,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [7:0]           r_mem [DEPTH];
  logic [ADDR_BITS-1:0] w_ea;
  logic [ADDR_BITS-1:0] w_ba [4];
  logic [3:0]           w_mask;
  logic [31:0]          w_raw;
  logic [31:0]          w_bmask;
  logic                 w_unused_addr;

  assign w_ea          = address[ADDR_BITS-1:0];
  assign w_unused_addr = &{1'b0, address[31:ADDR_BITS]};

  // each byte lane wraps modulo the depth on its own
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_ba[k] = w_ea + ADDR_BITS'(k);
    end
  end

  always_comb begin
    w_mask = 4'b0000;
    unique case (mem_ctrl)
      2'd0:    w_mask = 4'b0001;
      2'd1:    w_mask = 4'b0011;
      2'd2:    w_mask = 4'b1111;
      default: w_mask = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (w_mask[k]) begin
          r_mem[w_ba[k]] <= data_in[8*k +: 8];
        end
      end
    end
  end

  assign w_raw = {r_mem[w_ba[3]], r_mem[w_ba[2]],
                  r_mem[w_ba[1]], r_mem[w_ba[0]]};

  assign w_bmask = {{8{w_mask[3]}}, {8{w_mask[2]}},
                    {8{w_mask[1]}}, {8{w_mask[0]}}};

  assign data_out = rst_n ? (w_raw & w_bmask) : 32'h0;

endmodule

// File: tb/tb_ram.sv
// Directed vector bench for ram: table of reset/write/read
// operations plus hand sequences for edge timing and reset.
module tb_ram;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [1:0]  mem_ctrl;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;

  int n_total;
  int n_pass;

  ram #(.ADDR_BITS(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .mem_ctrl (mem_ctrl),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum logic [1:0] {OP_RST, OP_WR, OP_RD} op_e;

  typedef struct {
    op_e         op;
    logic [1:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(op_e op, logic [1:0] c,
                              logic [31:0] a, logic [31:0] d,
                              logic [31:0] e);
    vec_t v;
    v.op = op; v.ctrl = c; v.addr = a; v.din = d; v.exp = e;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] got,
                       logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, got, exp);
  endtask

  task automatic do_reset(logic [31:0] a);
    @(negedge clk);
    we = 1'b0; mem_ctrl = 2'd2; address = a;
    rst_n = 1'b0;
    #2;
    check("reset_out", data_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_write(logic [1:0] c, logic [31:0] a,
                          logic [31:0] d);
    @(negedge clk);
    we = 1'b1; mem_ctrl = c; address = a; data_in = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic do_read(string name, logic [1:0] c,
                         logic [31:0] a, logic [31:0] d,
                         logic [31:0] e);
    we = 1'b0; mem_ctrl = c; address = a; data_in = d;
    #1;
    check(name, data_out, e);
  endtask

  initial begin
    n_total = 0; n_pass = 0;
    rst_n = 1'b1; we = 1'b0; mem_ctrl = 2'd0;
    address = '0; data_in = '0;

    // byte writes
    vq.push_back(mk(OP_RST, 2, 0,  0, 0));
    vq.push_back(mk(OP_WR,  0, 0,  32'h12345678, 0));
    vq.push_back(mk(OP_WR,  0, 13, 32'h12345678, 0));
    vq.push_back(mk(OP_RD,  2, 0,  0, 32'h00000078));
    vq.push_back(mk(OP_RD,  0, 13, 0, 32'h00000078));
    vq.push_back(mk(OP_RD,  2, 12, 0, 32'h00007800));
    // halfword writes
    vq.push_back(mk(OP_RST, 2, 12, 0, 0));
    vq.push_back(mk(OP_WR,  1, 4,  32'h12345678, 0));
    vq.push_back(mk(OP_WR,  1, 14, 32'h12345678, 0));
    vq.push_back(mk(OP_RD,  1, 4,  0, 32'h00005678));
    vq.push_back(mk(OP_RD,  2, 4,  0, 32'h00005678));
    vq.push_back(mk(OP_RD,  2, 12, 0, 32'h56780000));
    // word write
    vq.push_back(mk(OP_RST, 2, 8,  0, 0));
    vq.push_back(mk(OP_WR,  2, 8,  32'h12345678, 0));
    vq.push_back(mk(OP_RD,  2, 8,  0, 32'h12345678));
    vq.push_back(mk(OP_RD,  0, 9,  0, 32'h00000056));
    vq.push_back(mk(OP_RD,  1, 10, 0, 32'h00001234));
    // wrap and alias
    vq.push_back(mk(OP_RST, 2, 1023, 0, 0));
    vq.push_back(mk(OP_WR,  2, 1023, 32'hAABBCCDD, 0));
    vq.push_back(mk(OP_RD,  0, 1023, 0, 32'h000000DD));
    vq.push_back(mk(OP_RD,  0, 0,    0, 32'h000000CC));
    vq.push_back(mk(OP_RD,  0, 1,    0, 32'h000000BB));
    vq.push_back(mk(OP_RD,  0, 2,    0, 32'h000000AA));
    vq.push_back(mk(OP_RD,  2, 1023, 0, 32'hAABBCCDD));
    vq.push_back(mk(OP_RD,  1, 1023, 0, 32'h0000CCDD));
    vq.push_back(mk(OP_WR,  2, 32'h400, 32'h11223344, 0));
    vq.push_back(mk(OP_RD,  2, 0,    0, 32'h11223344));
    vq.push_back(mk(OP_RD,  2, 1023, 0, 32'h223344DD));
    vq.push_back(mk(OP_RD,  2, 32'hFFFFFC00, 0, 32'h11223344));
    // reserved size and write disable
    vq.push_back(mk(OP_RST, 2, 8, 0, 0));
    vq.push_back(mk(OP_WR,  2, 8, 32'h12345678, 0));
    vq.push_back(mk(OP_WR,  3, 8, 32'hFFFFFFFF, 0));
    vq.push_back(mk(OP_RD,  3, 8, 32'hFFFFFFFF, 32'h0));
    vq.push_back(mk(OP_RD,  2, 8, 32'hFFFFFFFF, 32'h12345678));
    vq.push_back(mk(OP_RD,  0, 11, 0, 32'h00000012));

    foreach (vq[i]) begin
      unique case (vq[i].op)
        OP_RST: do_reset(vq[i].addr);
        OP_WR:  do_write(vq[i].ctrl, vq[i].addr, vq[i].din);
        default: do_read($sformatf("vec%0d", i), vq[i].ctrl,
                         vq[i].addr, vq[i].din, vq[i].exp);
      endcase
    end

    // same-cycle read shows old data before edge, new after
    do_reset(20);
    @(negedge clk);
    we = 1'b1; mem_ctrl = 2'd2; address = 20;
    data_in = 32'hCAFEBABE;
    #1;
    check("rw_before_edge", data_out, 32'h0);
    @(posedge clk);
    #1;
    check("rw_after_edge", data_out, 32'hCAFEBABE);
    we = 1'b0;

    // reserved size with write enabled reads zero
    @(negedge clk);
    we = 1'b1; mem_ctrl = 2'd3; data_in = 32'h0;
    #1;
    check("ctrl3_out", data_out, 32'h0);
    @(posedge clk);
    #1;
    we = 1'b0;
    do_read("ctrl3_nowrite", 2'd2, 20, 0, 32'hCAFEBABE);

    // reset pulse between edges clears immediately
    do_write(2'd2, 16, 32'h01020304);
    do_read("pre_reset", 2'd2, 16, 0, 32'h01020304);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_immediate", data_out, 32'h0);
    we = 1'b1; mem_ctrl = 2'd2; data_in = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    check("reset_held_write", data_out, 32'h0);
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    do_read("post_reset16", 2'd2, 16, 0, 32'h0);
    do_read("post_reset20", 2'd2, 20, 0, 32'h0);

    // first edge after reset release accepts a write
    do_write(2'd1, 30, 32'h0000BEEF);
    do_read("first_write", 2'd2, 30, 0, 32'h0000BEEF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
